// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I datapath: FSM state encoding,
// writeback / next-PC select codes, ALU and immediate format codes.
package mc_pkg;

  localparam int XLEN_DEF = 32;

  // Instruction sequencing states; encoding is fixed so debug tools can decode it.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // ResultSrc: writeback value select.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;
  localparam logic [1:0] RES_UOUT   = 2'b11;

  // {PCSrc1, PCSrc}: next-PC select. Any value with the high bit set picks ALUOut.
  localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
  localparam logic [1:0] PCSEL_TARGET = 2'b01;
  localparam logic [1:0] PCSEL_ALU    = 2'b10;

  // ALUControl codes, shared with the main decoder.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // ImmSrc codes.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate extraction; result is a 32-bit sign-extended value.
  function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                             input logic [2:0]  sel);
    logic [31:0] imm;
    imm = 32'd0;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_datapath_sequencer.sv
// Instruction sequencer: walks FETCH -> DECODE -> EXEC -> (MEM) -> WB, owns the
// shared memory port request/write strobes, the retire pulse and the stage
// register load enables used by the datapath.
//
// Memory handshake: mem_req_o is a registered request; a transfer completes on
// the rising edge where mem_req_o=1 and mem_ready_i=1. Until that edge the
// request, its write strobe (and the address/data the datapath derives from the
// stable state) do not change. There is no way to withdraw a request other
// than reset.
module mc_sequencer
  import mc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   mem_ready_i,
  input  logic   mem_access_i,
  input  logic   mem_write_i,
  output state_e state_o,
  output logic   mem_req_o,
  output logic   mem_we_o,
  output logic   retire_o,
  output logic   ir_en_o,
  output logic   dec_en_o,
  output logic   exec_en_o,
  output logic   mdr_en_o,
  output logic   wb_en_o
);

  state_e state_q;
  logic   mem_req_q;
  logic   mem_we_q;
  logic   retire_q;

  // Main FSM with registered request, write strobe and retire outputs.
  // After reset the FETCH request rises on the first clock edge, so mem_req
  // stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_req_q && mem_ready_i) begin
            state_q   <= S_DECODE;
            mem_req_q <= 1'b0;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (mem_access_i) begin
            state_q   <= S_MEM;
            mem_req_q <= 1'b1;
            mem_we_q  <= mem_write_i;
          end else begin
            state_q  <= S_WB;
            retire_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ready_i) begin
            state_q   <= S_WB;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            retire_q  <= 1'b1;
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          retire_q  <= 1'b0;
          mem_req_q <= 1'b1;
        end
        default: begin
          state_q   <= S_FETCH;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          retire_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage register enables decoded from the current state and handshake.
  always_comb begin
    ir_en_o   = (state_q == S_FETCH) && mem_req_q && mem_ready_i;
    dec_en_o  = (state_q == S_DECODE);
    exec_en_o = (state_q == S_EXEC);
    mdr_en_o  = (state_q == S_MEM) && mem_ready_i && !mem_we_q;
    wb_en_o   = (state_q == S_WB);
  end

  assign state_o   = state_q;
  assign mem_req_o = mem_req_q;
  assign mem_we_o  = mem_we_q;
  assign retire_o  = retire_q;

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I datapath with one shared memory port for fetch and
// load/store. The external main decoder watches Instr and drives the control
// inputs; each is only looked at in the state that uses it.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ResultSrc,
  input  logic             PCSrc,
  input  logic             PCSrc1,
  input  logic             ALUSrc,
  input  logic             UCtrl,
  input  logic             RegWrite,
  input  logic             MemAccess,
  input  logic             MemWrite,
  input  logic [2:0]       ImmSrc,
  input  logic [2:0]       ALUControl,
  output logic             Zero,
  output logic [XLEN-1:0]  PC,
  output logic [31:0]      Instr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ready,
  output logic [XLEN-1:0]  Result,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  localparam int SHW = $clog2(XLEN);

  // Stage registers.
  logic [XLEN-1:0]  pc_q;
  logic [31:0]      ir_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  imm_q;
  logic [XLEN-1:0]  aluout_q;
  logic [XLEN-1:0]  mdr_q;
  logic [XLEN-1:0]  pctarget_q;
  logic [1:0]       pcsel_q;
  logic [CNT_W-1:0] instret_q;

  // Next-state / combinational values.
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  pctarget_d;
  logic [XLEN-1:0]  aluout_d;
  logic [XLEN-1:0]  imm_d;
  logic [XLEN-1:0]  src_b;
  logic [XLEN-1:0]  uout;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [CNT_W-1:0] instret_d;

  // Register file; x0 reads as zero and writes to it are dropped.
  logic [XLEN-1:0]  rf_q [0:31];

  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  state_e seq_state;
  logic   ir_en;
  logic   dec_en;
  logic   exec_en;
  logic   mdr_en;
  logic   wb_en;

  mc_sequencer u_seq (
    .clk          (clk),
    .rst_n        (reset),
    .mem_ready_i  (mem_ready),
    .mem_access_i (MemAccess),
    .mem_write_i  (MemWrite),
    .state_o      (seq_state),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .retire_o     (retire),
    .ir_en_o      (ir_en),
    .dec_en_o     (dec_en),
    .exec_en_o    (exec_en),
    .mdr_en_o     (mdr_en),
    .wb_en_o      (wb_en)
  );

  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];
  assign rd_idx  = ir_q[11:7];

  // Register file read ports and immediate extension feeding the DECODE latch.
  always_comb begin
    rs1_val = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
    rs2_val = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
    imm_d   = XLEN'($signed(imm_extend(ir_q, ImmSrc)));
  end

  // ALU: A op SrcB, wrapping arithmetic; Zero is meaningful in EXEC.
  always_comb begin
    src_b = ALUSrc ? imm_q : b_q;
    case (ALUControl)
      ALU_ADD: aluout_d = a_q + src_b;
      ALU_SUB: aluout_d = a_q - src_b;
      ALU_AND: aluout_d = a_q & src_b;
      ALU_OR:  aluout_d = a_q | src_b;
      ALU_XOR: aluout_d = a_q ^ src_b;
      ALU_SLT: aluout_d = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(src_b))};
      ALU_SLL: aluout_d = a_q << src_b[SHW-1:0];
      ALU_SRL: aluout_d = a_q >> src_b[SHW-1:0];
      default: aluout_d = '0;
    endcase
    Zero = (aluout_d == '0);
  end

  // PC arithmetic, writeback mux and next-PC select.
  always_comb begin
    pc_plus4   = pc_q + XLEN'(4);
    pctarget_d = pc_q + imm_q;
    uout       = UCtrl ? imm_q : pctarget_q;
    case (ResultSrc)
      RES_ALUOUT: Result = aluout_q;
      RES_MDR:    Result = mdr_q;
      RES_PC4:    Result = pc_plus4;
      default:    Result = uout;
    endcase
    case (pcsel_q)
      PCSEL_PLUS4:  pc_d = pc_plus4;
      PCSEL_TARGET: pc_d = pctarget_q;
      default:      pc_d = aluout_q;
    endcase
    instret_d = instret_q + CNT_W'(1);
  end

  // Stage registers, each loaded only by its owning state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      aluout_q   <= '0;
      mdr_q      <= '0;
      pctarget_q <= '0;
      pcsel_q    <= PCSEL_PLUS4;
      instret_q  <= '0;
    end else begin
      if (ir_en) begin
        ir_q <= mem_rdata[31:0];
      end
      if (dec_en) begin
        a_q   <= rs1_val;
        b_q   <= rs2_val;
        imm_q <= imm_d;
      end
      if (exec_en) begin
        aluout_q   <= aluout_d;
        pctarget_q <= pctarget_d;
        pcsel_q    <= {PCSrc1, PCSrc};
      end
      if (mdr_en) begin
        mdr_q <= mem_rdata;
      end
      if (wb_en) begin
        pc_q      <= pc_d;
        instret_q <= instret_d;
      end
    end
  end

  // Register file write port, active only in WB.
  always_ff @(posedge clk) begin
    if (wb_en && RegWrite && (rd_idx != 5'd0)) begin
      rf_q[rd_idx] <= Result;
    end
  end

  // Shared port: PC during fetch, ALUOut during load/store. Both are stable
  // for the whole of their state, which keeps the address held while waiting.
  assign mem_addr  = (seq_state == S_MEM) ? aluout_q : pc_q;
  assign mem_wdata = b_q;

  assign PC      = pc_q;
  assign Instr   = ir_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a small program run against a wait-state
// capable memory model, with hand-computed results for each instruction.
module tb_mc_datapath;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ResultSrc;
  logic        PCSrc, PCSrc1, ALUSrc, UCtrl, RegWrite, MemAccess, MemWrite;
  logic [2:0]  ImmSrc, ALUControl;
  logic        Zero;
  logic [31:0] PC, Instr, mem_addr, mem_wdata, mem_rdata, Result, instret;
  logic        mem_req, mem_we, mem_ready, retire;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          wcnt   = 0;
  logic        pend_we = 1'b0;
  logic [31:0] pend_addr, pend_data;

  mc_datapath #(.XLEN(32), .RESET_PC(32'h100), .CNT_W(32)) dut (
    .clk(clk), .reset(rst_n), .ResultSrc(ResultSrc), .PCSrc(PCSrc),
    .PCSrc1(PCSrc1), .ALUSrc(ALUSrc), .UCtrl(UCtrl), .RegWrite(RegWrite),
    .MemAccess(MemAccess), .MemWrite(MemWrite), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Zero(Zero), .PC(PC), .Instr(Instr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .Result(Result), .retire(retire), .instret(instret)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Memory model: decides ready 2ns after each rising edge, wait_n cycles late.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pend_we && rst_n) mem[pend_addr[9:2]] = pend_data;
      pend_we = 1'b0;
      if (rst_n && mem_req) begin
        if (wcnt < wait_n) begin
          mem_ready = 1'b0;
          wcnt++;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) begin
            pend_we   = 1'b1;
            pend_addr = mem_addr;
            pend_data = mem_wdata;
          end
          wcnt = 0;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end
    end
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: control word as the main decoder would present it
  task automatic set_ctrl(input logic [1:0] rs, input logic p1, input logic p0,
                          input logic asrc, input logic uc, input logic rw,
                          input logic ma, input logic mw,
                          input logic [2:0] isrc, input logic [2:0] actl);
    ResultSrc = rs; PCSrc1 = p1; PCSrc = p0; ALUSrc = asrc; UCtrl = uc;
    RegWrite = rw; MemAccess = ma; MemWrite = mw; ImmSrc = isrc; ALUControl = actl;
  endtask

  // Driver: called at a falling edge inside a FETCH cycle with mem_req high;
  // returns at 1ns after the WB edge (next FETCH cycle).
  task automatic run_instr(input int data_wait, input logic [31:0] data_addr,
                           output int cycles, output logic zero_exec,
                           output int hold, output logic [31:0] res);
    cycles = 0; hold = 0; zero_exec = 1'b0; res = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) wait_n = data_wait;
      if (c == 3) zero_exec = Zero;
      if (c > 1 && mem_req && mem_addr == data_addr) hold++;
      if (retire) begin
        cycles = c;
        res    = Result;
        break;
      end
      @(negedge clk);
    end
    wait_n = 0;
    @(posedge clk);
    #1;
  endtask

  int          cyc, hold;
  logic        zx;
  logic [31:0] res;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h040 >> 2] = 32'hDEADBEEF;
    mem[32'h210 >> 2] = 32'h0BADF00D;
    mem[32'h100 >> 2] = 32'h00500093; // addi x1,x0,5
    mem[32'h104 >> 2] = 32'h00000463; // beq  x0,x0,+8
    mem[32'h10C >> 2] = 32'h04000093; // addi x1,x0,0x40
    mem[32'h110 >> 2] = 32'h0000A103; // lw   x2,0(x1)
    mem[32'h114 >> 2] = 32'h20000093; // addi x1,x0,0x200
    mem[32'h118 >> 2] = 32'h40208233; // sub  x4,x1,x2
    mem[32'h11C >> 2] = 32'h004081E7; // jalr x3,x1,4
    mem[32'h204 >> 2] = 32'h123452B7; // lui  x5,0x12345
    mem[32'h208 >> 2] = 32'h0030A823; // sw   x3,0x10(x1)
    set_ctrl(2'b00, 0, 0, 1, 0, 1, 0, 0, 3'b000, 3'b000);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_pc", PC, 32'h100);
    check("rst_instret", instret, 0);
    check("rst_retire", retire, 0);
    check("rst_instr", Instr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 32'h100);
    check("first_we", mem_we, 0);

    // addi x1,x0,5
    set_ctrl(2'b00, 0, 0, 1, 0, 1, 0, 0, 3'b000, 3'b000);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("addi5_cycles", cyc, 4);
    check("addi5_result", res, 5);
    check("addi5_x1", dut.rf_q[1], 5);
    check("addi5_pc", PC, 32'h104);
    check("addi5_instret", instret, 1);
    @(negedge clk);

    // beq x0,x0,+8 (taken: decoder sees Zero and raises PCSrc)
    set_ctrl(2'b00, 0, 1, 0, 0, 0, 0, 0, 3'b010, 3'b001);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("beq_cycles", cyc, 4);
    check("beq_zero", zx, 1);
    check("beq_pc", PC, 32'h10C);
    check("beq_fetch_addr", mem_addr, 32'h10C);
    check("beq_instret", instret, 2);
    @(negedge clk);

    // addi x1,x0,0x40
    set_ctrl(2'b00, 0, 0, 1, 0, 1, 0, 0, 3'b000, 3'b000);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("addi40_x1", dut.rf_q[1], 32'h40);
    check("addi40_pc", PC, 32'h110);
    @(negedge clk);

    // lw x2,0(x1) with two wait states on the data access
    set_ctrl(2'b01, 0, 0, 1, 0, 1, 1, 0, 3'b000, 3'b000);
    run_instr(2, 32'h40, cyc, zx, hold, res);
    check("lw_cycles", cyc, 7);
    check("lw_addr_hold", hold, 3);
    check("lw_result", res, 32'hDEADBEEF);
    check("lw_x2", dut.rf_q[2], 32'hDEADBEEF);
    check("lw_pc", PC, 32'h114);
    check("lw_instret", instret, 4);
    @(negedge clk);

    // addi x1,x0,0x200
    set_ctrl(2'b00, 0, 0, 1, 0, 1, 0, 0, 3'b000, 3'b000);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("addi200_x1", dut.rf_q[1], 32'h200);
    @(negedge clk);

    // sub x4,x1,x2 : 0x200 - 0xDEADBEEF wraps
    set_ctrl(2'b00, 0, 0, 0, 0, 1, 0, 0, 3'b000, 3'b001);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("sub_zero", zx, 0);
    check("sub_result", res, 32'h21524311);
    check("sub_x4", dut.rf_q[4], 32'h21524311);
    check("sub_pc", PC, 32'h11C);
    @(negedge clk);

    // jalr x3,x1,4
    set_ctrl(2'b10, 1, 0, 1, 0, 1, 0, 0, 3'b000, 3'b000);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("jalr_cycles", cyc, 4);
    check("jalr_result", res, 32'h120);
    check("jalr_x3", dut.rf_q[3], 32'h120);
    check("jalr_pc", PC, 32'h204);
    check("jalr_instret", instret, 7);
    @(negedge clk);

    // lui x5,0x12345 via UOut=ImmExt
    set_ctrl(2'b11, 0, 0, 1, 1, 1, 0, 0, 3'b100, 3'b000);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("lui_result", res, 32'h12345000);
    check("lui_x5", dut.rf_q[5], 32'h12345000);
    check("lui_pc", PC, 32'h208);
    @(negedge clk);

    // sw x3,0x10(x1) against a slow memory, reset pulsed while waiting
    set_ctrl(2'b00, 0, 0, 1, 0, 0, 1, 1, 3'b001, 3'b000);
    @(negedge clk);              // DECODE
    wait_n = 20;
    @(negedge clk);              // EXEC
    @(negedge clk);              // MEM, first cycle
    check("sw_req", mem_req, 1);
    check("sw_we", mem_we, 1);
    check("sw_addr", mem_addr, 32'h210);
    check("sw_wdata", mem_wdata, 32'h120);
    @(negedge clk);
    @(negedge clk);              // MEM, third cycle
    check("sw_addr_hold", mem_addr, 32'h210);
    rst_n = 1'b0;
    #1;
    check("midrst_req", mem_req, 0);
    check("midrst_pc", PC, 32'h100);
    check("midrst_instret", instret, 0);
    check("midrst_instr", Instr, 0);
    repeat (2) @(negedge clk);
    check("midrst_no_store", mem[32'h210 >> 2], 32'h0BADF00D);
    wait_n = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_req", mem_req, 1);
    check("rerst_addr", mem_addr, 32'h100);

    // Program restarts at RESET_PC
    set_ctrl(2'b00, 0, 0, 1, 0, 1, 0, 0, 3'b000, 3'b000);
    run_instr(0, 32'hFFFF_FFFF, cyc, zx, hold, res);
    check("restart_cycles", cyc, 4);
    check("restart_pc", PC, 32'h104);
    check("restart_instret", instret, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
